// File: rtl/cpu_pkg.sv
// cpu_pkg: shared architectural types and constants for writeback and execute stages
package cpu_pkg;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [0:63] data_t;
    typedef logic [0:3]  flags_t;
    localparam int FLAG_N   = 0;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int ZERO_REG = 31;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: zero-register/out-of-range masking and write-through bypass for one read port
module regfile_read_port import cpu_pkg::*; #(
    parameter int NREGS    = 32,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  reg_addr_t          addr,
    input  logic [0:DATA_W-1]  stored,
    input  logic               commit,
    input  reg_addr_t          write_addr,
    input  logic [0:DATA_W-1]  write_data,
    output logic [0:DATA_W-1]  data
);
    always_comb begin
        data = (addr == reg_addr_t'(ZERO_REG) || int'(addr) >= NREGS) ? '0 :
               (commit && write_addr == addr) ? write_data : stored;
    end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: integer register file, NZCV flags and committed-write counter fed by writeback
module writeback_regfile import cpu_pkg::*; #(
    parameter int NREGS    = 32,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              regwrite,
    input  reg_addr_t         write_addr,
    input  logic [0:DATA_W-1] write_data,
    input  logic              setflags,
    input  flags_t            flags,
    input  reg_addr_t         read_addr_a,
    input  reg_addr_t         read_addr_b,
    output logic [0:DATA_W-1] read_data_a,
    output logic [0:DATA_W-1] read_data_b,
    output flags_t            flags_out,
    output logic [CNT_W-1:0]  write_count
);
    logic [0:DATA_W-1] regs_q [NREGS];
    logic [0:DATA_W-1] regs_d [NREGS];
    flags_t            flags_q, flags_d;
    logic [CNT_W-1:0]  write_count_q, write_count_d;
    logic              reg_commit, flag_commit;

    assign reg_commit  = regwrite & ~halt & (write_addr != reg_addr_t'(ZERO_REG)) & (int'(write_addr) < NREGS);
    assign flag_commit = setflags & ~halt;

    always_comb begin
        regs_d = regs_q;
        if (reg_commit) regs_d[write_addr] = write_data;
        flags_d       = flag_commit ? flags : flags_q;
        write_count_d = write_count_q + CNT_W'(reg_commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q        <= '{default: '0};
            flags_q       <= '0;
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            flags_q       <= flags_d;
            write_count_q <= write_count_d;
        end
    end

    regfile_read_port #(.NREGS(NREGS), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_port_a (
        .addr(read_addr_a), .stored(regs_q[read_addr_a]), .commit(reg_commit),
        .write_addr(write_addr), .write_data(write_data), .data(read_data_a)
    );

    regfile_read_port #(.NREGS(NREGS), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_port_b (
        .addr(read_addr_b), .stored(regs_q[read_addr_b]), .commit(reg_commit),
        .write_addr(write_addr), .write_data(write_data), .data(read_data_b)
    );

    assign flags_out   = flag_commit ? flags : flags_q;
    assign write_count = write_count_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: scoreboard bench comparing writeback_regfile against an array-based reference model
module tb_writeback_regfile;
    logic        clk = 0;
    logic        rst, halt, regwrite, setflags;
    logic [4:0]  write_addr, read_addr_a, read_addr_b;
    logic [63:0] write_data;
    logic [3:0]  flags;
    logic [0:63] read_data_a, read_data_b, rd_a4, rd_b4;
    logic [0:3]  flags_out, flags_out4;
    logic [31:0] write_count;
    logic [3:0]  write_count4;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst(rst), .halt(halt), .regwrite(regwrite), .write_addr(write_addr),
        .write_data(write_data), .setflags(setflags), .flags(flags), .read_addr_a(read_addr_a),
        .read_addr_b(read_addr_b), .read_data_a(read_data_a), .read_data_b(read_data_b),
        .flags_out(flags_out), .write_count(write_count)
    );

    writeback_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .halt(halt), .regwrite(regwrite), .write_addr(write_addr),
        .write_data(write_data), .setflags(setflags), .flags(flags), .read_addr_a(read_addr_a),
        .read_addr_b(read_addr_b), .read_data_a(rd_a4), .read_data_b(rd_b4),
        .flags_out(flags_out4), .write_count(write_count4)
    );

    typedef struct {
        logic [63:0] a, b;
        logic [3:0]  f;
        logic [31:0] c;
        logic [3:0]  c4;
    } exp_t;

    exp_t        sb [$];
    event        drive_ev;
    int          checks = 0, errors = 0;
    logic [63:0] mreg [32];
    logic [3:0]  mflags;
    int unsigned mcount;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic rw, input logic [4:0] wa,
                        input logic [63:0] wd, input logic sf, input logic [3:0] fl,
                        input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        logic rc, fc;
        @(negedge clk);
        rst = r; halt = h; regwrite = rw; write_addr = wa; write_data = wd;
        setflags = sf; flags = fl; read_addr_a = a; read_addr_b = b;
        if (r) begin
            foreach (mreg[i]) mreg[i] = '0;
            mflags = '0;
            mcount = 0;
        end else begin
            rc = rw && !h && wa != 5'd31;
            fc = sf && !h;
            e.a  = (a == 5'd31) ? 64'd0 : (rc && wa == a) ? wd : mreg[a];
            e.b  = (b == 5'd31) ? 64'd0 : (rc && wa == b) ? wd : mreg[b];
            e.f  = fc ? fl : mflags;
            e.c  = mcount;
            e.c4 = 4'(mcount % 16);
            sb.push_back(e);
            -> drive_ev;
            if (rc) begin
                mreg[wa] = wd;
                mcount++;
            end
            if (fc) mflags = fl;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(drive_ev);
            #2;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: got empty queue expected entry");
            end else begin
                e = sb.pop_front();
                check("read_data_a", read_data_a, e.a);
                check("read_data_b", read_data_b, e.b);
                check("flags_out", {60'd0, flags_out}, {60'd0, e.f});
                check("write_count", {32'd0, write_count}, {32'd0, e.c});
                check("write_count_w4", {60'd0, write_count4}, {60'd0, e.c4});
            end
        end
    end

    initial begin
        logic [4:0] wa;
        rst = 1; halt = 0; regwrite = 0; write_addr = 0; write_data = 0;
        setflags = 0; flags = 0; read_addr_a = 0; read_addr_b = 0;
        // reset beats a simultaneous write
        step(1, 0, 1, 5'd3, 64'hFFFF, 1, 4'b1111, 5'd3, 5'd3);
        step(0, 0, 0, 5'd0, 64'd0, 0, 4'd0, 5'd3, 5'd0);
        step(0, 0, 1, 5'd5, 64'h0123_4567_89AB_CDEF, 0, 4'd0, 5'd5, 5'd4);
        step(0, 0, 0, 5'd0, 64'd0, 0, 4'd0, 5'd5, 5'd5);
        step(0, 0, 1, 5'd7, 64'hDEAD, 1, 4'b1010, 5'd7, 5'd7);
        step(0, 0, 0, 5'd0, 64'd0, 0, 4'd0, 5'd7, 5'd5);
        step(0, 0, 1, 5'd31, 64'h55, 0, 4'd0, 5'd31, 5'd31);
        step(0, 0, 0, 5'd0, 64'd0, 0, 4'd0, 5'd31, 5'd7);
        repeat (3) step(0, 1, 1, 5'd2, 64'h9, 1, 4'b0110, 5'd2, 5'd2);
        step(0, 0, 1, 5'd2, 64'h9, 1, 4'b0110, 5'd2, 5'd0);
        step(0, 0, 0, 5'd0, 64'd0, 0, 4'd0, 5'd2, 5'd2);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 5'(i % 31), {$urandom, $urandom}, 0, 4'd0, 5'(i % 31), 5'd1);
        for (int i = 0; i < 400; i++) begin
            wa = 5'($urandom_range(0, 31));
            step(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 3) != 0, wa,
                 {$urandom, $urandom}, ($urandom % 2) == 0, 4'($urandom),
                 ($urandom % 3 == 0) ? wa : 5'($urandom_range(0, 31)),
                 ($urandom % 3 == 0) ? wa : 5'($urandom_range(0, 31)));
        end
        step(0, 0, 0, 5'd0, 64'd0, 0, 4'd0, 5'd0, 5'd1);
        repeat (10) begin
            if (sb.size() != 0) @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
